// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multi-cycle CPU control unit:
// opcodes, ALU operation codes, FSM states and instruction field positions.
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_INV  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_ASHR = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_BN   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_PASSA = 3'd0;
    localparam logic [2:0] ALU_ADD   = 3'd1;
    localparam logic [2:0] ALU_INV   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_SHL   = 3'd4;
    localparam logic [2:0] ALU_ASHR  = 3'd5;
    localparam logic [2:0] ALU_PASSB = 3'd6;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RA_MSB  = 11;
    localparam int RA_LSB  = 10;
    localparam int RB_MSB  = 9;
    localparam int RB_LSB  = 8;
    localparam int TGT_MSB = 11;
    localparam int TGT_LSB = 0;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef struct packed {
        logic       mem_addr_sel;
        logic       mem_read;
        logic       mem_write;
        logic       regs_read1;
        logic       regs_read2;
        logic       regs_write;
        logic [2:0] alu_op;
        logic       wb_sel;
        logic       halted;
    } ctrl_t;

    function automatic logic [2:0] alu_op_for(input logic [3:0] op);
        logic [2:0] res;
        res = ALU_PASSA;
        case (op)
            OP_ADD:  res = ALU_ADD;
            OP_INV:  res = ALU_INV;
            OP_AND:  res = ALU_AND;
            OP_SHL:  res = ALU_SHL;
            OP_ASHR: res = ALU_ASHR;
            default: res = ALU_PASSA;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational decode: maps the current state, opcode and latched flags
// to the datapath control bundle, the register update enables and next state.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    input  logic       flag_n,
    input  logic       flag_z,
    output ctrl_t      ctrl,
    output state_t     next_state,
    output logic       ir_load,
    output logic       pc_jump,
    output logic       flags_load,
    output logic       set_illegal
);

    always_comb begin
        ctrl        = '0;
        next_state  = ST_FETCH;
        ir_load     = 1'b0;
        pc_jump     = 1'b0;
        flags_load  = 1'b0;
        set_illegal = 1'b0;

        case (state)
            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                ir_load       = 1'b1;
                next_state    = ST_DECODE;
            end
            ST_DECODE: begin
                next_state = (op == OP_HALT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                next_state = ST_FETCH;
                case (op)
                    OP_ADD, OP_INV, OP_AND, OP_SHL, OP_ASHR, OP_MOV: begin
                        ctrl.regs_read1 = 1'b1;
                        ctrl.regs_read2 = 1'b1;
                        ctrl.regs_write = 1'b1;
                        ctrl.alu_op     = alu_op_for(op);
                        flags_load      = 1'b1;
                    end
                    OP_LD: begin
                        ctrl.regs_read1   = 1'b1;
                        ctrl.mem_addr_sel = 1'b1;
                        ctrl.mem_read     = 1'b1;
                        next_state        = ST_WB;
                    end
                    OP_ST: begin
                        ctrl.regs_read1   = 1'b1;
                        ctrl.regs_read2   = 1'b1;
                        ctrl.mem_addr_sel = 1'b1;
                        ctrl.mem_write    = 1'b1;
                    end
                    OP_JMP:  pc_jump = 1'b1;
                    OP_BZ:   pc_jump = flag_z;
                    OP_BN:   pc_jump = flag_n;
                    4'hC, 4'hD, 4'hE: set_illegal = 1'b1;
                    default: ;
                endcase
            end
            // Address and read are held so the falling-edge memory read stays valid.
            ST_WB: begin
                ctrl.regs_read1   = 1'b1;
                ctrl.mem_addr_sel = 1'b1;
                ctrl.mem_read     = 1'b1;
                ctrl.wb_sel       = 1'b1;
                ctrl.regs_write   = 1'b1;
                next_state        = ST_FETCH;
            end
            ST_HALT: begin
                ctrl.halted = 1'b1;
                next_state  = ST_HALT;
            end
            default: next_state = ST_FETCH;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit: holds PC, IR, flags and the FETCH/DECODE/EXEC/WB
// state, and drives the register file, memory and ALU controls.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [15:0]     mem_data,
    input  logic            alu_n,
    input  logic            alu_z,
    output logic [PC_W-1:0] pc,
    output logic [15:0]     ir,
    output logic            mem_addr_sel,
    output logic            MEM_Read,
    output logic            MEM_Write,
    output logic            REGS_Read1,
    output logic            REGS_Read2,
    output logic            REGS_Write,
    output logic [1:0]      reg_addr1,
    output logic [1:0]      reg_addr2,
    output logic [2:0]      alu_op,
    output logic            wb_sel,
    output logic            flag_n,
    output logic            flag_z,
    output logic            halted,
    output logic            illegal
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;
    logic   ir_load;
    logic   pc_jump;
    logic   flags_load;
    logic   set_illegal;

    cpu_ctrl_decode u_decode (
        .state       (state),
        .op          (ir[OP_MSB:OP_LSB]),
        .flag_n      (flag_n),
        .flag_z      (flag_z),
        .ctrl        (ctrl),
        .next_state  (next_state),
        .ir_load     (ir_load),
        .pc_jump     (pc_jump),
        .flags_load  (flags_load),
        .set_illegal (set_illegal)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (ir_load) begin
                ir <= mem_data;
                pc <= pc + PC_W'(1);
            end
            if (pc_jump) begin
                pc <= ir[PC_W-1:0];
            end
            if (flags_load) begin
                flag_n <= alu_n;
                flag_z <= alu_z;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
        end
    end

    // Reset may land mid-store or mid-load; masking here keeps every strobe low that cycle.
    assign ctrl_out     = RST ? '0 : ctrl;

    assign mem_addr_sel = ctrl_out.mem_addr_sel;
    assign MEM_Read     = ctrl_out.mem_read;
    assign MEM_Write    = ctrl_out.mem_write;
    assign REGS_Read1   = ctrl_out.regs_read1;
    assign REGS_Read2   = ctrl_out.regs_read2;
    assign REGS_Write   = ctrl_out.regs_write;
    assign alu_op       = ctrl_out.alu_op;
    assign wb_sel       = ctrl_out.wb_sel;
    assign halted       = ctrl_out.halted;
    assign reg_addr1    = ir[RA_MSB:RA_LSB];
    assign reg_addr2    = ir[RB_MSB:RB_LSB];

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed scenarios plus random
// instruction streams checked against an instruction-level reference model.
module tb_cpu_ctrl_fsm;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] mem_data = '0;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b0;
    logic [11:0] pc;
    logic [15:0] ir;
    logic        mem_addr_sel, MEM_Read, MEM_Write;
    logic        REGS_Read1, REGS_Read2, REGS_Write;
    logic [1:0]  reg_addr1, reg_addr2;
    logic [2:0]  alu_op;
    logic        wb_sel, flag_n, flag_z, halted, illegal;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] m_pc;
    logic        m_fn, m_fz, m_ill;

    cpu_ctrl_fsm #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .CLK(CLK), .RST(RST), .mem_data(mem_data), .alu_n(alu_n), .alu_z(alu_z),
        .pc(pc), .ir(ir), .mem_addr_sel(mem_addr_sel), .MEM_Read(MEM_Read),
        .MEM_Write(MEM_Write), .REGS_Read1(REGS_Read1), .REGS_Read2(REGS_Read2),
        .REGS_Write(REGS_Write), .reg_addr1(reg_addr1), .reg_addr2(reg_addr2),
        .alu_op(alu_op), .wb_sel(wb_sel), .flag_n(flag_n), .flag_z(flag_z),
        .halted(halted), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    // Observed control bundle: {asel, rd, wr, r1, r2, rw, alu[2:0], wb, halt}
    logic [10:0] obs;
    assign obs = {mem_addr_sel, MEM_Read, MEM_Write, REGS_Read1, REGS_Read2,
                  REGS_Write, alu_op, wb_sel, halted};

    function automatic logic [10:0] vec(input bit asel, input bit rd, input bit wr,
                                        input bit r1, input bit r2, input bit rw,
                                        input logic [2:0] alu, input bit wb, input bit hlt);
        return {asel, rd, wr, r1, r2, rw, alu, wb, hlt};
    endfunction

    // What the EXEC cycle must look like for each opcode class.
    function automatic logic [10:0] exec_vec(input logic [3:0] op);
        logic [2:0] alu;
        alu = (op == 4'h6) ? 3'd0 : op[2:0];
        if (op >= 4'h1 && op <= 4'h6) return vec(0, 0, 0, 1, 1, 1, alu, 0, 0);
        if (op == 4'h7) return vec(1, 1, 0, 1, 0, 0, 3'd0, 0, 0);
        if (op == 4'h8) return vec(1, 0, 1, 1, 1, 0, 3'd0, 0, 0);
        return '0;
    endfunction

    localparam logic [10:0] FETCH_V = 11'b01000000000;
    localparam logic [10:0] HALT_V  = 11'b00000000001;
    localparam logic [10:0] WB_V    = 11'b11010100010;

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        next_cycle();
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: got %h expected %h", obs, 11'd0);
        end
        RST = 1'b0;
        #1;
        vectors++;
        if ({pc, ir, flag_n, flag_z, halted, illegal} !== {12'h000, 16'h0000, 4'b0000}) begin
            miscompares++;
            $display("[TB] FAIL reset_regs: got pc=%h ir=%h n=%b z=%b h=%b i=%b expected zeros",
                     pc, ir, flag_n, flag_z, halted, illegal);
        end
        m_pc = 12'h000; m_fn = 1'b0; m_fz = 1'b0; m_ill = 1'b0;
    endtask

    // Executes one instruction from FETCH, checking every cycle against the model.
    task automatic run_instr(input logic [15:0] instr, input logic an, input logic az);
        logic [3:0] op;
        op = instr[15:12];
        mem_data = instr; alu_n = 1'($urandom); alu_z = 1'($urandom);
        vectors++;
        if (obs !== FETCH_V || pc !== m_pc) begin
            miscompares++;
            $display("[TB] FAIL fetch: got ctrl=%h pc=%h expected ctrl=%h pc=%h", obs, pc, FETCH_V, m_pc);
        end
        next_cycle();
        m_pc = m_pc + 12'd1;
        mem_data = 16'($urandom);
        vectors++;
        if (obs !== 11'd0 || ir !== instr || pc !== m_pc ||
            reg_addr1 !== instr[11:10] || reg_addr2 !== instr[9:8]) begin
            miscompares++;
            $display("[TB] FAIL decode: got ctrl=%h ir=%h pc=%h ra=%0d rb=%0d expected ctrl=0 ir=%h pc=%h",
                     obs, ir, pc, reg_addr1, reg_addr2, instr, m_pc);
        end
        next_cycle();
        if (op == 4'hF) begin
            vectors++;
            if (obs !== HALT_V) begin
                miscompares++;
                $display("[TB] FAIL halt_entry: got %h expected %h", obs, HALT_V);
            end
            return;
        end
        alu_n = an; alu_z = az;
        vectors++;
        if (obs !== exec_vec(op)) begin
            miscompares++;
            $display("[TB] FAIL exec op=%h: got %h expected %h", op, obs, exec_vec(op));
        end
        next_cycle();
        if (op >= 4'h1 && op <= 4'h6) begin m_fn = an; m_fz = az; end
        if (op == 4'h9 || (op == 4'hA && m_fz) || (op == 4'hB && m_fn)) m_pc = instr[11:0];
        if (op >= 4'hC && op <= 4'hE) m_ill = 1'b1;
        if (op == 4'h7) begin
            alu_n = 1'($urandom); alu_z = 1'($urandom);
            mem_data = 16'($urandom);
            vectors++;
            if (obs !== WB_V) begin
                miscompares++;
                $display("[TB] FAIL writeback: got %h expected %h", obs, WB_V);
            end
            next_cycle();
        end
        vectors++;
        if (pc !== m_pc || flag_n !== m_fn || flag_z !== m_fz || illegal !== m_ill || obs !== FETCH_V) begin
            miscompares++;
            $display("[TB] FAIL retire op=%h: got pc=%h n=%b z=%b i=%b ctrl=%h expected pc=%h n=%b z=%b i=%b ctrl=%h",
                     op, pc, flag_n, flag_z, illegal, obs, m_pc, m_fn, m_fz, m_ill, FETCH_V);
        end
    endtask

    task automatic test_reset();
        do_reset();
        run_instr(16'h0000, 1'b0, 1'b0);
        vectors++;
        if (pc !== 12'h001 || illegal !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL nop_pc: got pc=%h ill=%b expected pc=001 ill=0", pc, illegal);
        end
    endtask

    task automatic test_alu();
        do_reset();
        run_instr(16'h1100, 1'b0, 1'b1);
        vectors++;
        if (flag_z !== 1'b1 || flag_n !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL add_flags: got n=%b z=%b expected n=0 z=1", flag_n, flag_z);
        end
    endtask

    task automatic test_load();
        do_reset();
        run_instr(16'h7400, 1'b1, 1'b1);
        vectors++;
        if (pc !== 12'h001 || flag_n !== 1'b0 || flag_z !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ld_retire: got pc=%h n=%b z=%b expected pc=001 n=0 z=0", pc, flag_n, flag_z);
        end
    endtask

    task automatic test_branch();
        do_reset();
        run_instr(16'hA123, 1'b0, 1'b0);
        vectors++;
        if (pc !== 12'h001) begin
            miscompares++;
            $display("[TB] FAIL bz_not_taken: got %h expected 001", pc);
        end
        do_reset();
        run_instr(16'h6000, 1'b0, 1'b1);
        run_instr(16'hA123, 1'b0, 1'b0);
        vectors++;
        if (pc !== 12'h123) begin
            miscompares++;
            $display("[TB] FAIL bz_taken: got %h expected 123", pc);
        end
    endtask

    task automatic test_illegal_halt();
        do_reset();
        run_instr(16'hC000, 1'b0, 1'b0);
        run_instr(16'hF000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mem_data = 16'($urandom); alu_n = 1'($urandom); alu_z = 1'($urandom);
            next_cycle();
            vectors++;
            if (obs !== HALT_V || illegal !== 1'b1 || pc !== 12'h002) begin
                miscompares++;
                $display("[TB] FAIL halt_hold: got ctrl=%h ill=%b pc=%h expected ctrl=%h ill=1 pc=002",
                         obs, illegal, pc, HALT_V);
            end
        end
        do_reset();
    endtask

    task automatic test_wrap_and_mid_store_reset();
        do_reset();
        run_instr(16'h9FFF, 1'b0, 1'b0);
        run_instr(16'h0000, 1'b0, 1'b0);
        vectors++;
        if (pc !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL pc_wrap: got %h expected 000", pc);
        end
        mem_data = 16'h8100;
        next_cycle();
        next_cycle();
        vectors++;
        if (MEM_Write !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL st_exec: got MEM_Write=%b expected 1", MEM_Write);
        end
        RST = 1'b1;
        #1;
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++;
            $display("[TB] FAIL st_reset_strobes: got %h expected 0", obs);
        end
        next_cycle();
        RST = 1'b0;
        #1;
        vectors++;
        if (obs !== FETCH_V || pc !== 12'h000 || ir !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL st_reset_state: got ctrl=%h pc=%h ir=%h expected ctrl=%h pc=000 ir=0000",
                     obs, pc, ir, FETCH_V);
        end
        m_pc = 12'h000; m_fn = 1'b0; m_fz = 1'b0; m_ill = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            logic [15:0] instr;
            instr = {4'($urandom_range(0, 14)), 12'($urandom)};
            run_instr(instr, 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_illegal_halt();
        test_wrap_and_mid_store_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle control unit that sequences the 4-entry register file, the 4K x 16 memory and the 16-bit ALU into a simple stored-program processor. It holds PC, IR and the N/Z flags, and runs FETCH/DECODE/EXEC/WB states. For each state it drives the register-file and memory strobes, the ALU opcode and the datapath mux selects. It sits at the top of the processor beside the datapath; memory data is sampled on the falling clock edge, so read data is valid by the next rising edge.

Parameters:
PC_W, 12, program counter / memory address width
RESET_PC, 12'h000, PC value loaded by reset

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST  in  1  synchronous, active-high reset
mem_data  in  16  memory read data (instruction or load data)
alu_n  in  1  ALU negative flag, current cycle
alu_z  in  1  ALU zero flag, current cycle
pc  out  12  program counter
ir  out  16  instruction register
mem_addr_sel  out  1  0: memory address = pc; 1: memory address = register read port 1 [11:0]
MEM_Read  out  1  memory read strobe
MEM_Write  out  1  memory write strobe (write data = register read port 2)
REGS_Read1  out  1  register read port 1 enable
REGS_Read2  out  1  register read port 2 enable
REGS_Write  out  1  register write enable (destination = reg_addr2)
reg_addr1  out  2  = ir[11:10] (ra)
reg_addr2  out  2  = ir[9:8] (rb, also the destination)
alu_op  out  3  ALU operation select
wb_sel  out  1  0: write-back from ALU; 1: write-back from memory
flag_n  out  1  latched N flag
flag_z  out  1  latched Z flag
halted  out  1  high in HALT state
illegal  out  1  sticky; set on an undefined opcode

Behaviour:
- Instruction word: op = ir[15:12], ra = ir[11:10], rb = ir[9:8], target = ir[11:0].
- Opcodes and actions:
  - 0 NOP
  - 1 ADD: rb = ra + rb
  - 2 INV: rb = ~ra
  - 3 AND: rb = ra & rb
  - 4 SHL: rb = ra << 1
  - 5 ASHR: rb = ra >>> 1
  - 6 MOV: rb = ra
  - 7 LD: rb = M[ra]
  - 8 ST: M[ra] = rb
  - 9 JMP target
  - A BZ target
  - B BN target
  - F HALT
  - C, D, E: illegal; set illegal and execute as NOP.
- ALU opcode mapping: ADD=1, INV=2, AND=3, SHL=4, ASHR=5, MOV=0 (pass A).
- States: FETCH, DECODE, EXEC, WB, HALT.
- Default in every state: all strobes 0, mem_addr_sel 0, wb_sel 0, alu_op 0.
- FETCH: MEM_Read=1, mem_addr_sel=0. At the rising edge: ir<=mem_data, pc<=pc+1 (modulo 4096; 4095 wraps to 0), next state DECODE.
- DECODE: no strobes. Next state is HALT for op F, otherwise EXEC.
- EXEC, ALU ops (1-6): REGS_Read1=REGS_Read2=1, alu_op per the mapping, wb_sel=0, REGS_Write=1. flag_n<=alu_n and flag_z<=alu_z at the same edge. Next state FETCH.
- EXEC, LD: REGS_Read1=1, mem_addr_sel=1, MEM_Read=1. Next state WB.
- WB (LD only): REGS_Read1=1, mem_addr_sel=1 and MEM_Read=1 are held so the falling-edge read stays valid; wb_sel=1, REGS_Write=1. Next state FETCH. Flags are unchanged.
- EXEC, ST: REGS_Read1=REGS_Read2=1, mem_addr_sel=1, MEM_Write=1. Next state FETCH.
- EXEC, JMP: pc<=target. BZ: pc<=target if flag_z. BN: pc<=target if flag_n. Otherwise pc is unchanged. Next state FETCH.
- EXEC, NOP or illegal: no strobes, next state FETCH. For illegal opcodes, illegal<=1.
- HALT: all strobes 0, halted=1. The block stays in HALT until RST.
- Cycle counts: ALU, ST, branch and NOP take 3 cycles; LD takes 4; HALT is entered 2 cycles after its fetch.
- MEM_Write and REGS_Write are never asserted in the same cycle. MEM_Read and MEM_Write are never asserted together.
- Reset (any state, including mid-LD or mid-ST): state=FETCH, pc=RESET_PC, ir=0, flags=0, halted=0, illegal=0, all strobes 0 in the reset cycle. No write strobe is issued in the cycle RST is high.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams OP_NOP..OP_HALT
  - ALU opcode constants ALU_PASSA, ALU_ADD, ALU_INV, ALU_AND, ALU_SHL, ALU_ASHR, ALU_PASSB
  - state encoding
  - instruction field bit positions
- One combinational sub-module, cpu_ctrl_decode: maps (state, op, flag_n, flag_z) to the strobe/select bundle and next state. The top module holds the registers (state, pc, ir, flags, illegal).

Test Plan:
- Reset, then 3 clocks with M[0]=16'h0000 (NOP) -> FETCH strobes MEM_Read=1 at pc=0; pc=1 after the first edge; back in FETCH on the 4th cycle; illegal=0.
- M[0]=16'h1100 (ADD ra=0, rb=1), alu_z=1 driven in EXEC -> in cycle 3: REGS_Read1, REGS_Read2, REGS_Write =1, alu_op=1, wb_sel=0; flag_z=1 afterward.
- M[0]=16'h7400 (LD ra=1, rb=0) -> EXEC and WB both have mem_addr_sel=1 and MEM_Read=1; WB has REGS_Write=1, wb_sel=1; next FETCH at pc=1 on cycle 5.
- M[0]=16'hA123 (BZ) with flag_z=0, then rerun with flag_z=1 -> first run pc=1; second run pc=12'h123.
- M[0]=16'hC000 then M[1]=16'hF000 -> illegal=1 after cycle 3; halted=1 from cycle 6 with all strobes 0; RST asserted for one cycle clears both and pc=0.
- pc forced to 4095 via JMP 16'h9FFF, then NOP at 4095 -> pc wraps to 0; RST asserted during the EXEC of an ST -> MEM_Write=0 in the reset cycle, state FETCH.
